mul12u_acc_stream: RTL and testbench

Streaming accumulator placed directly downstream of the 12x12 unsigned approximate multipliers (mul12u_* family). It consumes one 24-bit product per beat over a valid/ready handshake, sums a block of products terminated by `in_last`, and presents the block sum, beat count and overflow flag on a registered valid/ready output. Product bits below `DROP` are discarded before accumulation. The truncated multipliers drive these bits to constant zero, so the accumulator is narrower and costs fewer LUTs.

---
 rtl/mul12u_acc_stream.sv | 105 ++++++++++
 tb/tb_mul12u_acc_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul12u_acc_stream.sv
// Block-sum accumulator for mul12u_* products over valid/ready.
// Optional macro MUL12U_ACC_SAT_EN: saturate instead of wrapping.
module mul12u_acc_stream #(
  parameter int PROD_W = 24,
  parameter int DROP   = 17,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int AW = ACC_W - DROP;

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_ovf;

  logic             w_beat;
  logic             w_res_hs;
  logic [AW-1:0]    w_term;
  logic [AW:0]      w_add;
  logic             w_carry;
  logic [AW-1:0]    w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;
  logic [ACC_W-1:0] w_res;
  logic             w_unused;

  assign out_valid = (r_state == S_HOLD);
  assign in_ready  = !out_valid | out_ready;
  assign w_beat    = in_valid & in_ready;
  assign w_res_hs  = out_valid & out_ready;

  // truncating multipliers hold the dropped LSBs at zero
  assign w_unused  = ^in_prod;
  assign w_term    = AW'(in_prod[PROD_W-1:DROP]);
  assign w_add     = {1'b0, r_acc} + {1'b0, w_term};
  assign w_carry   = w_add[AW];

`ifdef MUL12U_ACC_SAT_EN
  // once clamped, any nonzero term carries again
  assign w_acc_nxt = w_carry ? '1 : w_add[AW-1:0];
`else
  assign w_acc_nxt = w_add[AW-1:0];
`endif

  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_ovf_nxt = r_ovf | w_carry;
  assign w_res     = ACC_W'(w_acc_nxt) << DROP;

  // acc is already clear in HOLD, so a beat
  // taken on the result handshake starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      if (w_beat && in_last) begin
        r_sum     <= w_res;
        r_out_cnt <= w_cnt_nxt;
        r_out_ovf <= w_ovf_nxt;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
        r_state   <= S_HOLD;
      end else if (w_beat) begin
        r_acc     <= w_acc_nxt;
        r_cnt     <= w_cnt_nxt;
        r_ovf     <= w_ovf_nxt;
        r_state   <= S_ACC;
      end else if (w_res_hs) begin
        r_state   <= S_ACC;
      end
    end
  end

  assign out_sum   = r_sum;
  assign out_count = r_out_cnt;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mul12u_acc_stream.sv
// Bench for mul12u_acc_stream: vector table, scoreboard queue,
// hand-written backpressure / reset / back-to-back sequences.
module tb_mul12u_acc_stream;

  logic        clk;
  logic        rst;
  logic [23:0] in_prod;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  mul12u_acc_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_prod   (in_prod),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [23:0] prod;
    logic        last;
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } vec_t;

  res_t q[$];
  int   pop_cyc[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] s, input logic [7:0] c,
                          input logic o);
    res_t r;
    r.sum = s;
    r.cnt = c;
    r.ovf = o;
    q.push_back(r);
  endtask

  task automatic beat(input logic [23:0] p, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    res_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", out_sum, 32'hDEADBEEF);
      end else begin
        e = q.pop_front();
        chk("out_sum", out_sum, e.sum);
        chk("out_count", 32'(out_count), 32'(e.cnt));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   k;
    tbl[0] = '{24'h020000, 1'b0, 32'h0, 8'd0, 1'b0};
    tbl[1] = '{24'h040000, 1'b0, 32'h0, 8'd0, 1'b0};
    tbl[2] = '{24'h060000, 1'b1, 32'h000C0000, 8'd3, 1'b0};
    tbl[3] = '{24'h01FFFF, 1'b1, 32'h00000000, 8'd1, 1'b0};
    tbl[4] = '{24'hFFFFFF, 1'b0, 32'h0, 8'd0, 1'b0};
    tbl[5] = '{24'h000001, 1'b1, 32'h00FE0000, 8'd2, 1'b0};
    tbl[6] = '{24'h100000, 1'b1, 32'h00100000, 8'd1, 1'b0};

    rst       = 1'b1;
    in_prod   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].last) push_exp(tbl[i].sum, tbl[i].cnt, tbl[i].ovf);
      beat(tbl[i].prod, tbl[i].last);
      if (tbl[i].last) chk("latency_valid", 32'(out_valid), 32'd1);
    end

    for (int i = 0; i < 259; i++) begin
      if (i == 258) begin
`ifdef MUL12U_ACC_SAT_EN
        push_exp(32'hFFFE0000, 8'd3, 1'b1);
`else
        push_exp(32'h00FA0000, 8'd3, 1'b1);
`endif
      end
      beat(24'hFE0000, i == 258);
    end
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    push_exp(32'h00020000, 8'd1, 1'b0);
    beat(24'h020000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", out_sum, 32'h00020000);
      chk("bp_count", 32'(out_count), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_exp(32'h00100000, 8'd1, 1'b0);
    beat(24'h100000, 1'b1);
    chk("bp_nogap_valid", 32'(out_valid), 32'd1);
    chk("bp_nogap_sum", out_sum, 32'h00100000);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    beat(24'h040000, 1'b1);
    chk("hold_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", out_sum, 32'd0);
    chk("arst_count", 32'(out_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    beat(24'h020000, 1'b0);
    beat(24'h020000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_sum", out_sum, 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    push_exp(32'h00020000, 8'd1, 1'b0);
    beat(24'h020000, 1'b1);
    @(posedge clk);
    #1;

    k = pop_cyc.size();
    for (int i = 0; i < 4; i++) begin
      push_exp(32'((i + 1) * 32'h20000), 8'd1, 1'b0);
      in_valid = 1'b1;
      in_prod  = 24'((i + 1) * 24'h020000);
      in_last  = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_results", 32'(pop_cyc.size() - k), 32'd4);
    if (pop_cyc.size() == k + 4) begin
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", 32'(pop_cyc[k+i] - pop_cyc[k+i-1]), 32'd1);
    end
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
